mem_arb_ctrl: RTL and testbench
===============================

MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 SHALL have parameter: TO_CYCLES, default 64, maximum cycles in BUSY waiting for mem_ack before abort.
REQ-002 SHALL have port: i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: i_reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports for the fetch requester: if_req in 1 (access request); if_addr in 32 (word address); if_ack out 1 (one-cycle completion pulse); if_rdata out 32 (fetched instruction).
REQ-005 SHALL have ports for the load/store requester: ls_req in 1; ls_wren in 1 (1 = store); ls_addr in 32; ls_wdata in 32; ls_bmask in 4 (byte enables); ls_ack out 1; ls_rdata out 32.
REQ-006 SHALL have ports for the shared memory: mem_req out 1; mem_wren out 1; mem_addr out 32; mem_wdata out 32; mem_bmask out 4; mem_rdata in 32; mem_ack in 1 (one-cycle completion, variable latency >= 0 cycles after mem_req rises).
REQ-007 SHALL have status ports: busy out 1 (state != IDLE); timeout_err out 1 (sticky abort flag).

Function
REQ-008 SHALL implement FSM states IDLE, BUSY_IF, BUSY_LS, DONE.
REQ-009 SHALL, in IDLE with only one request high, grant that requester at the next edge.
REQ-010 SHALL, in IDLE with both requests high, grant the requester not granted last (last_grant register); last_grant SHALL update on every grant.
REQ-011 SHALL, at grant, latch address/wren/wdata/bmask into mem_* registers; fetch grant drives mem_wren=0, mem_wdata=0, mem_bmask=4'b1111.
REQ-012 SHALL hold mem_req=1 and all mem_* fields stable for the whole BUSY_IF/BUSY_LS state; mem_req=0 in IDLE and DONE.
REQ-013 SHALL, on mem_ack=1 in BUSY_x, go to DONE, capture mem_rdata into x_rdata (load/fetch only; a store leaves ls_rdata unchanged) and assert x_ack=1 for exactly the DONE cycle.
REQ-014 SHALL leave DONE for IDLE unconditionally after one cycle and SHALL NOT arbitrate in DONE (a requester dropping req after ack is never re-granted).
REQ-015 SHALL ignore mem_ack in IDLE and DONE.
REQ-016 SHALL keep a wait counter cleared at grant and incremented each BUSY cycle without mem_ack; at count == TO_CYCLES-1 without mem_ack the block SHALL go to DONE, ack the requester with x_rdata=32'h0, and set timeout_err=1.
REQ-017 SHALL keep timeout_err set until reset; subsequent accesses SHALL proceed normally.
REQ-018 SHALL give minimum latency: req high in IDLE cycle N -> mem_req high cycle N+1 -> (mem_ack at N+1) -> x_ack cycle N+2; peak throughput one access per 3 cycles.
REQ-019 SHALL require requesters to hold req and payload until their ack; changes after grant SHALL not affect the current access.

Reset
REQ-020 SHALL, on i_reset=0 at any time including mid-access, asynchronously force state IDLE, counter 0, last_grant=IF, and all outputs (mem_*, if_*, ls_*, busy, timeout_err) to 0.
REQ-021 SHALL start arbitration on the first rising edge after i_reset returns to 1; an access in flight at reset SHALL be dropped without ack.

Verification
REQ-022 Single fetch: if_req=1, if_addr=0x100, mem_ack one cycle after mem_req with mem_rdata=0x00500093 -> mem_addr=0x100, mem_bmask=1111, if_ack one pulse, if_rdata=0x00500093.
REQ-023 Tie after reset: if_req=ls_req=1 -> LS granted first (last_grant=IF), IF granted at next IDLE; mem_req low during each DONE cycle.
REQ-024 Store: ls_wren=1, ls_addr=0x2004, ls_wdata=0xDEADBEEF, ls_bmask=0011 -> mem_wren=1 with those exact fields; ls_ack pulses; ls_rdata unchanged.
REQ-025 Timeout: TO_CYCLES=8, mem_ack never asserted -> mem_req drops after 8 BUSY cycles, if_ack=1 with if_rdata=0, timeout_err=1 and stays 1 across next successful access.
REQ-026 Reset mid-access: i_reset=0 while BUSY_LS -> all outputs 0 immediately, no ls_ack; after release with ls_req still high, access reissued from scratch.
REQ-027 Stray ack: mem_ack=1 while IDLE -> no x_ack, no state change.

Source files
------------

// File: rtl/mem_arb_ctrl_if.sv
// mem_arb_ctrl_if: bundle of all bus/handshake signals around the memory
// arbiter.
//   Fetch requester : if_req, if_addr -> if_ack, if_rdata
//   Load/store req. : ls_req, ls_wren, ls_addr, ls_wdata, ls_bmask -> ls_ack, ls_rdata
//   Shared memory   : mem_req, mem_wren, mem_addr, mem_wdata, mem_bmask <- mem_rdata, mem_ack
// Modports:
//   slave  - the arbiter's view (requests and memory responses come in).
//   master - the environment's view (drives requests and memory responses).
interface mem_arb_ctrl_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;

    logic        ls_req;
    logic        ls_wren;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_bmask;
    logic        ls_ack;
    logic [31:0] ls_rdata;

    logic        mem_req;
    logic        mem_wren;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bmask;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata,
        input  ls_req, ls_wren, ls_addr, ls_wdata, ls_bmask,
        output ls_ack, ls_rdata,
        output mem_req, mem_wren, mem_addr, mem_wdata, mem_bmask,
        input  mem_rdata, mem_ack
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata,
        output ls_req, ls_wren, ls_addr, ls_wdata, ls_bmask,
        input  ls_ack, ls_rdata,
        input  mem_req, mem_wren, mem_addr, mem_wdata, mem_bmask,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: two-requester (instruction fetch, load/store) arbiter in
// front of a single variable-latency memory port.
//   i_clk       - sole clock, rising edge.
//   i_reset     - asynchronous active-low reset.
//   bus         - mem_arb_ctrl_if.slave: requester and memory handshakes.
//   busy        - high whenever the FSM is not IDLE.
//   timeout_err - sticky; set when an access is aborted for lack of mem_ack.
// Each access takes IDLE -> BUSY_x -> DONE -> IDLE, so at most one access
// per three cycles. Ties are broken towards the requester not granted last.
module mem_arb_ctrl #(
    parameter int unsigned TO_CYCLES = 64
) (
    input  logic          i_clk,
    input  logic          i_reset,
    mem_arb_ctrl_if.slave bus,
    output logic          busy,
    output logic          timeout_err
);

    localparam int unsigned CW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_LS = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_LS = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t        state_q;
    logic          last_grant_q;
    logic [CW-1:0] cnt_q;
    logic          mem_req_q;
    logic          mem_wren_q;
    logic [31:0]   mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [3:0]    mem_bmask_q;
    logic          if_ack_q;
    logic [31:0]   if_rdata_q;
    logic          ls_ack_q;
    logic [31:0]   ls_rdata_q;
    logic          busy_q;
    logic          timeout_err_q;

    logic          grant_if_s;
    logic          grant_ls_s;

    // Arbitration decision for the IDLE state; a tie goes to whoever was not granted last.
    always_comb begin
        grant_if_s = 1'b0;
        grant_ls_s = 1'b0;
        if (bus.if_req && bus.ls_req) begin
            if (last_grant_q == GRANT_IF) begin
                grant_ls_s = 1'b1;
            end else begin
                grant_if_s = 1'b1;
            end
        end else if (bus.if_req) begin
            grant_if_s = 1'b1;
        end else if (bus.ls_req) begin
            grant_ls_s = 1'b1;
        end else begin
            grant_if_s = 1'b0;
            grant_ls_s = 1'b0;
        end
    end

    // Access FSM with all outputs registered; acks are one-cycle pulses coinciding with DONE.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= GRANT_IF;
            cnt_q         <= {CW{1'b0}};
            mem_req_q     <= 1'b0;
            mem_wren_q    <= 1'b0;
            mem_addr_q    <= 32'h0000_0000;
            mem_wdata_q   <= 32'h0000_0000;
            mem_bmask_q   <= 4'b0000;
            if_ack_q      <= 1'b0;
            if_rdata_q    <= 32'h0000_0000;
            ls_ack_q      <= 1'b0;
            ls_rdata_q    <= 32'h0000_0000;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            ls_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // mem_ack is ignored here; only requests matter.
                    if (grant_if_s) begin
                        state_q      <= ST_BUSY_IF;
                        busy_q       <= 1'b1;
                        last_grant_q <= GRANT_IF;
                        cnt_q        <= {CW{1'b0}};
                        mem_req_q    <= 1'b1;
                        mem_wren_q   <= 1'b0;
                        mem_addr_q   <= bus.if_addr;
                        mem_wdata_q  <= 32'h0000_0000;
                        mem_bmask_q  <= 4'b1111;
                    end else if (grant_ls_s) begin
                        state_q      <= ST_BUSY_LS;
                        busy_q       <= 1'b1;
                        last_grant_q <= GRANT_LS;
                        cnt_q        <= {CW{1'b0}};
                        mem_req_q    <= 1'b1;
                        mem_wren_q   <= bus.ls_wren;
                        mem_addr_q   <= bus.ls_addr;
                        mem_wdata_q  <= bus.ls_wdata;
                        mem_bmask_q  <= bus.ls_bmask;
                    end else begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        mem_req_q <= 1'b0;
                    end
                end
                ST_BUSY_IF, ST_BUSY_LS: begin
                    if (bus.mem_ack) begin
                        state_q   <= ST_DONE;
                        mem_req_q <= 1'b0;
                        if (state_q == ST_BUSY_IF) begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= bus.mem_rdata;
                        end else begin
                            ls_ack_q <= 1'b1;
                            // A store completes without touching the load data register.
                            if (!mem_wren_q) begin
                                ls_rdata_q <= bus.mem_rdata;
                            end else begin
                                ls_rdata_q <= ls_rdata_q;
                            end
                        end
                    end else if (cnt_q == TO_LAST) begin
                        // Abort: ack with zero data and flag the error permanently.
                        state_q       <= ST_DONE;
                        mem_req_q     <= 1'b0;
                        timeout_err_q <= 1'b1;
                        if (state_q == ST_BUSY_IF) begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= 32'h0000_0000;
                        end else begin
                            ls_ack_q   <= 1'b1;
                            ls_rdata_q <= 32'h0000_0000;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    // No arbitration here, so a requester dropping req after its ack is never re-granted.
                    state_q   <= ST_IDLE;
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_wren  = mem_wren_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_bmask = mem_bmask_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_ack    = ls_ack_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign busy          = busy_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// tb_mem_arb_ctrl: scoreboard bench for mem_arb_ctrl (TO_CYCLES = 8).
// Expected memory transactions and acks are queued when stimulus is driven
// and popped by a monitor as the DUT produces them.
module tb_mem_arb_ctrl;

    typedef struct {
        logic        wren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
    } mem_item_t;

    typedef struct {
        logic        is_ls;
        logic [31:0] rdata;
    } ack_item_t;

    logic i_clk;
    logic i_reset;
    logic busy;
    logic timeout_err;

    mem_arb_ctrl_if bus ();

    mem_arb_ctrl #(.TO_CYCLES(8)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int n_vec = 0;
    int n_err = 0;
    int ack_cnt = 0;

    mem_item_t mem_q[$];
    ack_item_t ack_q[$];

    // memory responder controls
    bit resp_en = 1'b1;
    bit stray   = 1'b0;
    int lat     = 0;

    // model of the requester-visible read data registers
    logic [31:0] m_if_rdata;
    logic [31:0] m_ls_rdata;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // Memory model: acks after 'lat' extra BUSY cycles, plus optional stray acks.
    initial begin : responder
        int wcnt;
        wcnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge i_clk);
            #1;
            bus.mem_ack = stray;
            if (bus.mem_req && resp_en) begin
                if (wcnt == lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdata_of(bus.mem_addr);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: checks each issued transaction, field stability, and each ack.
    logic      prev_req = 1'b0;
    mem_item_t cur;
    always @(negedge i_clk) begin
        if (bus.mem_req && !prev_req) begin
            if (mem_q.size() == 0) begin
                chk_eq("unexpected_mem_req", 32'd1, 32'd0);
            end else begin
                cur = mem_q.pop_front();
                chk_eq("mem_wren",  {31'd0, bus.mem_wren}, {31'd0, cur.wren});
                chk_eq("mem_addr",  bus.mem_addr, cur.addr);
                chk_eq("mem_wdata", bus.mem_wdata, cur.wdata);
                chk_eq("mem_bmask", {28'd0, bus.mem_bmask}, {28'd0, cur.bmask});
            end
        end else if (bus.mem_req && prev_req) begin
            chk_eq("mem_addr_stable", bus.mem_addr, cur.addr);
            chk_eq("mem_wdata_stable", bus.mem_wdata, cur.wdata);
        end
        prev_req = bus.mem_req;
        if (bus.if_ack || bus.ls_ack) begin
            ack_cnt++;
            chk_eq("single_ack", {31'd0, bus.if_ack & bus.ls_ack}, 32'd0);
            chk_eq("mem_req_in_done", {31'd0, bus.mem_req}, 32'd0);
            if (ack_q.size() == 0) begin
                chk_eq("unexpected_ack", 32'd1, 32'd0);
            end else begin
                ack_item_t a;
                a = ack_q.pop_front();
                chk_eq("ack_who", {31'd0, bus.ls_ack}, {31'd0, a.is_ls});
                chk_eq("ack_rdata", a.is_ls ? bus.ls_rdata : bus.if_rdata, a.rdata);
            end
        end
    end

    // Waits (bounded) for any ack; reports cycles taken and cycles with mem_req high.
    task automatic wait_ack(output int cyc, output int req_cyc);
        bit got;
        got = 1'b0;
        cyc = 0;
        req_cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge i_clk);
            cyc++;
            if (bus.mem_req) req_cyc++;
            if (bus.if_ack || bus.ls_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk_eq("ack_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic push_fetch(input logic [31:0] addr, input logic [31:0] rd);
        mem_q.push_back('{wren: 1'b0, addr: addr, wdata: 32'h0, bmask: 4'b1111});
        ack_q.push_back('{is_ls: 1'b0, rdata: rd});
        m_if_rdata = rd;
    endtask

    task automatic push_ls(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] bm, input logic [31:0] rd);
        mem_q.push_back('{wren: wr, addr: addr, wdata: wd, bmask: bm});
        if (!wr) m_ls_rdata = rd;
        ack_q.push_back('{is_ls: 1'b1, rdata: m_ls_rdata});
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] rd,
                            output int cyc, output int req_cyc);
        push_fetch(addr, rd);
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        wait_ack(cyc, req_cyc);
        bus.if_req  = 1'b0;
        bus.if_addr = 32'hFFFF_FFFF;   // payload changes after ack must not matter
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_busy"},     {31'd0, busy}, 32'd0);
        chk_eq({tag, "_timeout"},  {31'd0, timeout_err}, 32'd0);
        chk_eq({tag, "_mem_req"},  {31'd0, bus.mem_req}, 32'd0);
        chk_eq({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        chk_eq({tag, "_mem_bmask"}, {28'd0, bus.mem_bmask}, 32'd0);
        chk_eq({tag, "_if_ack"},   {31'd0, bus.if_ack}, 32'd0);
        chk_eq({tag, "_ls_ack"},   {31'd0, bus.ls_ack}, 32'd0);
        chk_eq({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
        chk_eq({tag, "_ls_rdata"}, bus.ls_rdata, 32'd0);
    endtask

    initial begin : main
        int cyc, rcyc, a0;
        i_reset      = 1'b0;
        bus.if_req   = 1'b0;
        bus.if_addr  = 32'h0;
        bus.ls_req   = 1'b0;
        bus.ls_wren  = 1'b0;
        bus.ls_addr  = 32'h0;
        bus.ls_wdata = 32'h0;
        bus.ls_bmask = 4'b0000;
        m_if_rdata   = 32'h0;
        m_ls_rdata   = 32'h0;

        repeat (3) @(negedge i_clk);
        chk_all_zero("reset");
        i_reset = 1'b1;
        @(negedge i_clk);

        // stray ack in IDLE: no state change, no ack
        a0 = ack_cnt;
        stray = 1'b1;
        repeat (2) @(negedge i_clk);
        chk_eq("stray_busy", {31'd0, busy}, 32'd0);
        stray = 1'b0;
        @(negedge i_clk);
        chk_eq("stray_no_ack", ack_cnt, a0);
        chk_eq("stray_mem_req", {31'd0, bus.mem_req}, 32'd0);

        // single fetch, ack one cycle after mem_req rises
        lat = 1;
        do_fetch(32'h0000_0100, 32'h0050_0093, cyc, rcyc);
        chk_eq("fetch_lat", cyc, 32'd3);
        @(negedge i_clk);
        chk_eq("fetch_if_rdata_hold", bus.if_rdata, 32'h0050_0093);

        // minimum latency fetch
        lat = 0;
        do_fetch(32'h0000_0104, rdata_of(32'h0000_0104), cyc, rcyc);
        chk_eq("min_lat", cyc, 32'd2);
        chk_eq("min_lat_busy_cycles", rcyc, 32'd1);
        @(negedge i_clk);

        // tie right after reset: LS first, then IF
        i_reset = 1'b0;
        m_if_rdata = 32'h0;
        m_ls_rdata = 32'h0;
        @(negedge i_clk);
        i_reset = 1'b1;
        lat = 2;
        push_ls(1'b0, 32'h0000_1000, 32'h1111_2222, 4'b0101, rdata_of(32'h0000_1000));
        push_fetch(32'h0000_0200, rdata_of(32'h0000_0200));
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h0000_0200;
        bus.ls_req   = 1'b1;
        bus.ls_wren  = 1'b0;
        bus.ls_addr  = 32'h0000_1000;
        bus.ls_wdata = 32'h1111_2222;
        bus.ls_bmask = 4'b0101;
        wait_ack(cyc, rcyc);
        chk_eq("tie_first_ls", {31'd0, bus.ls_ack}, 32'd1);
        bus.ls_req = 1'b0;
        wait_ack(cyc, rcyc);
        chk_eq("tie_second_if", {31'd0, bus.if_ack}, 32'd1);
        bus.if_req = 1'b0;
        @(negedge i_clk);

        // store: exact fields, ls_rdata untouched
        lat = 1;
        push_ls(1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 4'b0011, 32'h0);
        bus.ls_req   = 1'b1;
        bus.ls_wren  = 1'b1;
        bus.ls_addr  = 32'h0000_2004;
        bus.ls_wdata = 32'hDEAD_BEEF;
        bus.ls_bmask = 4'b0011;
        wait_ack(cyc, rcyc);
        bus.ls_req = 1'b0;
        bus.ls_wren = 1'b0;
        @(negedge i_clk);
        chk_eq("store_ls_rdata", bus.ls_rdata, rdata_of(32'h0000_1000));

        // timeout: no mem_ack at all
        resp_en = 1'b0;
        do_fetch(32'h0000_0300, 32'h0, cyc, rcyc);
        chk_eq("timeout_busy_cycles", rcyc, 32'd8);
        chk_eq("timeout_err_set", {31'd0, timeout_err}, 32'd1);
        resp_en = 1'b1;
        @(negedge i_clk);
        lat = 2;
        do_fetch(32'h0000_0304, rdata_of(32'h0000_0304), cyc, rcyc);
        chk_eq("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);
        @(negedge i_clk);

        // reset in the middle of a load: dropped, then reissued from scratch
        lat = 6;
        mem_q.push_back('{wren: 1'b0, addr: 32'h0000_0400, wdata: 32'h0, bmask: 4'b1111});
        push_ls(1'b0, 32'h0000_0400, 32'h0, 4'b1111, rdata_of(32'h0000_0400));
        bus.ls_req   = 1'b1;
        bus.ls_wren  = 1'b0;
        bus.ls_addr  = 32'h0000_0400;
        bus.ls_wdata = 32'h0;
        bus.ls_bmask = 4'b1111;
        repeat (3) @(negedge i_clk);
        chk_eq("mid_busy_before", {31'd0, busy}, 32'd1);
        a0 = ack_cnt;
        i_reset = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(negedge i_clk);
        @(negedge i_clk);
        chk_eq("mid_no_ack", ack_cnt, a0);
        i_reset = 1'b1;
        wait_ack(cyc, rcyc);
        chk_eq("mid_reissue_busy_cycles", rcyc, 32'd7);
        bus.ls_req = 1'b0;
        @(negedge i_clk);
        chk_eq("mid_ls_rdata", bus.ls_rdata, rdata_of(32'h0000_0400));
        chk_eq("mid_timeout_cleared", {31'd0, timeout_err}, 32'd0);

        repeat (3) @(negedge i_clk);
        chk_eq("mem_q_empty", mem_q.size(), 32'd0);
        chk_eq("ack_q_empty", ack_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
